// File: rtl/bus_arbiter_if.sv
// Bundle of the CPU/DMA requester ports and the device-side bus of bus_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface bus_arbiter_if;
  logic        c_req;
  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [3:0]  c_byteen;
  logic        c_gnt;
  logic        c_done;
  logic        c_err;
  logic [31:0] c_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteen;
  logic        d_gnt;
  logic        d_done;
  logic        d_err;
  logic [31:0] d_rdata;

  logic [3:0]  m_sel;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_byteen;
  logic [31:0] m_rdata_dm;
  logic [31:0] m_rdata_tc0;
  logic [31:0] m_rdata_tc1;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_byteen,
    output c_gnt, c_done, c_err, c_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_byteen,
    output d_gnt, d_done, d_err, d_rdata,
    output m_sel, m_addr, m_wdata, m_byteen,
    input  m_rdata_dm, m_rdata_tc0, m_rdata_tc1
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, c_byteen,
    input  c_gnt, c_done, c_err, c_rdata,
    output d_req, d_we, d_addr, d_wdata, d_byteen,
    input  d_gnt, d_done, d_err, d_rdata,
    input  m_sel, m_addr, m_wdata, m_byteen,
    output m_rdata_dm, m_rdata_tc0, m_rdata_tc1
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin CPU/DMA arbiter onto a decoded device bus (DM, TC0, TC1, INT).
// Define BUS_WAIT_EN to add WAIT_CYCLES wait cycles to timer (TC0/TC1) accesses.
module bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic          clk,
  input logic          reset,
  bus_arbiter_if.slave bus
);

`ifdef BUS_WAIT_EN
  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2,
    StWait   = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  logic unused_wait_cycles;
  assign unused_wait_cycles = ^WAIT_CYCLES;
`endif

  function automatic logic [3:0] addr_decode(input logic [31:0] a);
    logic [3:0] s;
    s = 4'b0000;
    if (a <= 32'h0000_2FFF) begin
      s = 4'b0001;
    end else if (a >= 32'h0000_7F00 && a <= 32'h0000_7F0B) begin
      s = 4'b0010;
    end else if (a >= 32'h0000_7F10 && a <= 32'h0000_7F1B) begin
      s = 4'b0100;
    end else if (a >= 32'h0000_7F20 && a <= 32'h0000_7F23) begin
      s = 4'b1000;
    end
    return s;
  endfunction

  state_e      state_q, state_d;
  logic        owner_q, owner_d;   // 0: CPU, 1: DMA
  logic        last_q, last_d;     // requester granted most recently
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  byteen_q, byteen_d;
  logic [3:0]  sel_q, sel_d;
`ifdef BUS_WAIT_EN
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  logic        win_dma;
  logic        c_gnt, d_gnt, c_done, d_done, c_err, d_err;
  logic [31:0] c_rdata, d_rdata, resp_rdata;
  logic [3:0]  m_sel, m_byteen;
  logic [31:0] m_addr, m_wdata;

  // On a tie the requester not granted last wins; a lone requester always wins.
  assign win_dma = bus.c_req ? (bus.d_req & ~last_q) : bus.d_req;

  always_comb begin
    if (sel_q[0]) begin
      resp_rdata = bus.m_rdata_dm;
    end else if (sel_q[1]) begin
      resp_rdata = bus.m_rdata_tc0;
    end else if (sel_q[2]) begin
      resp_rdata = bus.m_rdata_tc1;
    end else begin
      resp_rdata = 32'h0;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    byteen_d = byteen_q;
    sel_d    = sel_q;
`ifdef BUS_WAIT_EN
    cnt_d    = cnt_q;
`endif
    c_gnt    = 1'b0;
    d_gnt    = 1'b0;
    c_done   = 1'b0;
    d_done   = 1'b0;
    c_err    = 1'b0;
    d_err    = 1'b0;
    c_rdata  = 32'h0;
    d_rdata  = 32'h0;
    m_sel    = 4'b0000;
    m_addr   = 32'h0;
    m_wdata  = 32'h0;
    m_byteen = 4'b0000;

    unique case (state_q)
      StIdle: begin
        if ((bus.c_req || bus.d_req) && !reset) begin
          state_d  = StAccess;
          owner_d  = win_dma;
          last_d   = win_dma;
          we_d     = win_dma ? bus.d_we     : bus.c_we;
          addr_d   = win_dma ? bus.d_addr   : bus.c_addr;
          wdata_d  = win_dma ? bus.d_wdata  : bus.c_wdata;
          byteen_d = win_dma ? bus.d_byteen : bus.c_byteen;
          sel_d    = addr_decode(win_dma ? bus.d_addr : bus.c_addr);
          c_gnt    = ~win_dma;
          d_gnt    = win_dma;
        end
      end

      StAccess: begin
        m_sel    = sel_q;
        m_addr   = addr_q;
        m_wdata  = wdata_q;
        m_byteen = (we_q && sel_q != 4'b0000) ? byteen_q : 4'b0000;
`ifdef BUS_WAIT_EN
        if ((sel_q[1] || sel_q[2]) && (WAIT_CYCLES != 0)) begin
          state_d = StWait;
          cnt_d   = CntW'(WAIT_CYCLES - 1);
        end else begin
          state_d = StResp;
        end
`else
        state_d  = StResp;
`endif
      end

`ifdef BUS_WAIT_EN
      StWait: begin
        m_sel    = sel_q;
        m_addr   = addr_q;
        m_wdata  = wdata_q;
        m_byteen = we_q ? byteen_q : 4'b0000;
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif

      StResp: begin
        state_d = StIdle;
        if (owner_q) begin
          d_done  = 1'b1;
          d_err   = (sel_q == 4'b0000);
          d_rdata = resp_rdata;
        end else begin
          c_done  = 1'b1;
          c_err   = (sel_q == 4'b0000);
          c_rdata = resp_rdata;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;  // CPU wins the first tie after reset
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      byteen_q <= 4'b0000;
      sel_q    <= 4'b0000;
`ifdef BUS_WAIT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      byteen_q <= byteen_d;
      sel_q    <= sel_d;
`ifdef BUS_WAIT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus.c_gnt    = c_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.c_done   = c_done;
  assign bus.d_done   = d_done;
  assign bus.c_err    = c_err;
  assign bus.d_err    = d_err;
  assign bus.c_rdata  = c_rdata;
  assign bus.d_rdata  = d_rdata;
  assign bus.m_sel    = m_sel;
  assign bus.m_addr   = m_addr;
  assign bus.m_wdata  = m_wdata;
  assign bus.m_byteen = m_byteen;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level reference model.
module tb_bus_arbiter;
  localparam int unsigned WaitCycles = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;

  bus_arbiter_if bus ();

  bus_arbiter #(
    .WAIT_CYCLES(WaitCycles)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a transaction occupies a fixed number of cycles after its grant.
  int          m_busy;      // cycles elapsed since grant, 0 when idle
  int          m_len;       // device-phase cycles (access plus waits)
  logic        m_owner;
  logic        m_last;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  int          m_region;    // 0 error, 1 DM, 2 TC0, 3 TC1, 4 INT

  function automatic int ref_region(input logic [31:0] a);
    if (a < 32'h3000) return 1;
    if (a >= 32'h7F00 && a < 32'h7F0C) return 2;
    if (a >= 32'h7F10 && a < 32'h7F1C) return 3;
    if (a >= 32'h7F20 && a < 32'h7F24) return 4;
    return 0;
  endfunction

  function automatic int ref_waits(input int region);
`ifdef BUS_WAIT_EN
    return (region == 2 || region == 3) ? WaitCycles : 0;
`else
    return (region < 0) ? 1 : 0;
`endif
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_last = 1'b1;
  endtask

  // Compare all outputs for the current cycle, then advance the model past the next edge.
  task automatic step();
    logic [1:0]  e_gnt = 2'b00, e_done = 2'b00, e_err = 2'b00;
    logic [31:0] e_crd = 0, e_drd = 0, e_addr = 0, e_wdata = 0, rd;
    logic [3:0]  e_sel = 0, e_be = 0;
    logic        w;
    #1;
    if (m_busy == 0) begin
      if (bus.c_req || bus.d_req) begin
        w        = (bus.c_req && bus.d_req) ? ~m_last : bus.d_req;
        e_gnt    = w ? 2'b01 : 2'b10;
        m_owner  = w;
        m_last   = w;
        m_we     = w ? bus.d_we : bus.c_we;
        m_addr   = w ? bus.d_addr : bus.c_addr;
        m_wdata  = w ? bus.d_wdata : bus.c_wdata;
        m_be     = w ? bus.d_byteen : bus.c_byteen;
        m_region = ref_region(m_addr);
        m_len    = 1 + ref_waits(m_region);
        m_busy   = 1;
      end
    end else if (m_busy <= m_len) begin
      e_sel   = (m_region == 0) ? 4'b0000 : 4'(1 << (m_region - 1));
      e_addr  = m_addr;
      e_wdata = m_wdata;
      e_be    = (m_we && m_region != 0) ? m_be : 4'b0000;
      m_busy++;
    end else begin
      case (m_region)
        1:       rd = bus.m_rdata_dm;
        2:       rd = bus.m_rdata_tc0;
        3:       rd = bus.m_rdata_tc1;
        default: rd = 32'h0;
      endcase
      if (m_owner) begin
        e_done = 2'b01;
        e_err  = {1'b0, m_region == 0};
        e_drd  = rd;
      end else begin
        e_done = 2'b10;
        e_err  = {m_region == 0, 1'b0};
        e_crd  = rd;
      end
      m_busy = 0;
    end
    check("gnt", {30'h0, bus.c_gnt, bus.d_gnt}, {30'h0, e_gnt});
    check("done", {30'h0, bus.c_done, bus.d_done}, {30'h0, e_done});
    check("err", {30'h0, bus.c_err, bus.d_err}, {30'h0, e_err});
    check("c_rdata", bus.c_rdata, e_crd);
    check("d_rdata", bus.d_rdata, e_drd);
    check("m_sel", {28'h0, bus.m_sel}, {28'h0, e_sel});
    check("m_addr", bus.m_addr, e_addr);
    check("m_wdata", bus.m_wdata, e_wdata);
    check("m_byteen", {28'h0, bus.m_byteen}, {28'h0, e_be});
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0; bus.c_byteen = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_byteen = 0;
    bus.m_rdata_dm = 0; bus.m_rdata_tc0 = 0; bus.m_rdata_tc1 = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 11))
      0:       return 32'($urandom_range(0, 32'h2FFF));
      1:       return 32'h0000_2FFF;
      2:       return 32'h0000_3000;
      3:       return 32'($urandom_range(32'h7F00, 32'h7F0B));
      4:       return 32'h0000_7F0C;
      5:       return 32'($urandom_range(32'h7F10, 32'h7F1B));
      6:       return 32'h0000_7F1C;
      7:       return 32'($urandom_range(32'h7F20, 32'h7F23));
      8:       return 32'h0000_7F24;
      9:       return 32'h0000_4000;
      10:      return 32'h0000_7EFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_random();
    bus.c_req = ($urandom_range(0, 2) != 0); bus.c_we = $urandom; bus.c_addr = rand_addr();
    bus.c_wdata = $urandom; bus.c_byteen = 4'($urandom);
    bus.d_req = ($urandom_range(0, 2) != 0); bus.d_we = $urandom; bus.d_addr = rand_addr();
    bus.d_wdata = $urandom; bus.d_byteen = 4'($urandom);
    bus.m_rdata_dm = $urandom; bus.m_rdata_tc0 = $urandom; bus.m_rdata_tc1 = $urandom;
  endtask

  initial begin
    int order[$];
    int bits;
    idle_inputs();
    model_reset();
    reset = 1'b1;
    tick();
    bus.c_req = 1; bus.d_req = 1;
    #1;
    check("rst_gnt", {30'h0, bus.c_gnt, bus.d_gnt}, 32'h0);
    check("rst_sel", {28'h0, bus.m_sel}, 32'h0);
    tick();
    reset = 1'b0;
    idle_inputs();
    step(); tick();

    // Ties held high from reset: CPU, DMA, CPU.
    bus.c_req = 1; bus.d_req = 1; bus.c_addr = 32'h100; bus.d_addr = 32'h200;
    for (int i = 0; i < 9; i++) begin
      step();
      if (bus.c_gnt) order.push_back(0);
      if (bus.d_gnt) order.push_back(1);
      tick();
    end
    idle_inputs();
    check("tie_count", order.size(), 3);
    bits = 0;
    foreach (order[i]) bits = bits * 2 + order[i];
    check("tie_order", bits, 3'b010);
    step(); tick();

    // Lone CPU read of DM.
    bus.c_req = 1; bus.c_addr = 32'h10; bus.m_rdata_dm = 32'hDEAD_BEEF;
    step(); tick();
    bus.c_req = 0; bus.c_addr = 32'h7F04;
    step(); check("rd_sel", {28'h0, bus.m_sel}, 32'h1); tick();
    step(); check("rd_done", bus.c_done, 1); check("rd_data", bus.c_rdata, 32'hDEAD_BEEF);
    tick();
    step(); check("rd_done_once", bus.c_done, 0); tick();

    // DMA write to TC0.
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h7F04; bus.d_byteen = 4'hF;
    bus.d_wdata = 32'h1234;
    step(); tick();
    bus.d_req = 0; bus.d_byteen = 4'h0;
    step();
    check("wr_sel", {28'h0, bus.m_sel}, 32'h2);
    check("wr_be", {28'h0, bus.m_byteen}, 32'hF);
    tick();
    for (int i = 0; i < 6; i++) begin step(); tick(); end

    // CPU write to an unmapped address.
    bus.c_req = 1; bus.c_we = 1; bus.c_addr = 32'h4000; bus.c_byteen = 4'hF;
    bus.m_rdata_dm = 32'h5555_AAAA; bus.m_rdata_tc0 = 32'h1; bus.m_rdata_tc1 = 32'h2;
    step(); tick();
    bus.c_req = 0;
    step(); check("err_sel", {28'h0, bus.m_sel, bus.m_byteen}, 32'h0); tick();
    step(); check("err_pulse", {30'h0, bus.c_done, bus.c_err}, 32'h3);
    check("err_rdata", bus.c_rdata, 32'h0);
    tick();
    idle_inputs();
    step(); tick();

    // Reset during ACCESS after a CPU grant: no done, CPU still wins the next tie.
    bus.c_req = 1; bus.c_addr = 32'h20;
    step(); tick();
    bus.c_req = 0;
    step();
    #1 reset = 1'b1; bus.c_req = 1; bus.d_req = 1;
    #1;
    check("mid_rst_out", {bus.c_gnt, bus.d_gnt, bus.c_done, bus.d_done, bus.c_err, bus.d_err,
                          bus.m_sel, bus.m_byteen}, 32'h0);
    check("mid_rst_addr", bus.m_addr | bus.m_wdata | bus.c_rdata | bus.d_rdata, 32'h0);
    model_reset();
    tick();
    reset = 1'b0;
    step(); check("post_rst_cpu", {30'h0, bus.c_gnt, bus.d_gnt}, 32'h2); tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin step(); tick(); end

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      drive_random();
      step(); tick();
    end
    idle_inputs();
    for (int i = 0; i < 8; i++) begin step(); tick(); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, which sets the extra ACCESS cycles for timer-region accesses when BUS_WAIT_EN is defined.
REQ-002 clk  in  1  single system clock, rising edge.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 c_req, c_we  in  1 each  CPU (requester 0) request and write flag.
REQ-005 c_addr, c_wdata  in  32 each  CPU address and write data; c_byteen  in  4  CPU byte enables.
REQ-006 c_gnt, c_done, c_err  out  1 each  CPU grant, completion pulse, and address error.
REQ-007 c_rdata  out  32  CPU read data.
REQ-008 d_req, d_we, d_addr, d_wdata, d_byteen, d_gnt, d_done, d_err, d_rdata SHALL mirror the CPU ports for requester 1 (DMA), with identical widths and directions.
REQ-009 m_sel  out  4  one-hot device select: bit0 DM, bit1 TC0, bit2 TC1, bit3 INT.
REQ-010 m_addr  out  32, m_wdata  out  32, m_byteen  out  4  address, data and byte enables forwarded to the device.
REQ-011 m_rdata_dm, m_rdata_tc0, m_rdata_tc1  in  32 each  device read data, valid in the cycle after the select.

Function
REQ-012 The FSM SHALL have states IDLE, ACCESS, WAIT and RESP.
REQ-013 From IDLE with any request pending, the FSM SHALL latch the winner's request fields, assert the winner's gnt for that cycle, and go to ACCESS.
REQ-014 Arbitration SHALL be round-robin: on simultaneous requests the requester not granted last wins, and a lone requester always wins.
REQ-015 Address decode SHALL be:
  - DM: 0x0000_0000..0x0000_2FFF
  - TC0: 0x0000_7F00..0x0000_7F0B
  - TC1: 0x0000_7F10..0x0000_7F1B
  - INT: 0x0000_7F20..0x0000_7F23
  - any other address is an error
REQ-016 In ACCESS the block SHALL drive m_sel, m_addr and m_wdata from the latched request, and SHALL drive m_byteen = latched byteen only for writes (4'b0000 for reads).
REQ-017 An error address SHALL drive m_sel = 0 and m_byteen = 0, and the access SHALL still complete through RESP with err = 1.
REQ-018 After ACCESS the FSM SHALL go to RESP, which captures rdata from the selected device (INT or error reads return 0) and pulses the owner's done for exactly one cycle.
REQ-019 done, err and rdata SHALL appear only on the ports of the granted requester; the other requester's ports SHALL read 0.
REQ-020 Minimum latency SHALL be 3 cycles from request sampled in IDLE to the done pulse: IDLE, then ACCESS, then RESP.
REQ-021 The FSM SHALL return from RESP to IDLE, so back-to-back transactions are separated by one IDLE cycle.
REQ-022 Once a request is latched, dropping req SHALL NOT abort the transaction, and changes to its fields SHALL be ignored.
REQ-023 Outside ACCESS and WAIT, m_sel and m_byteen SHALL be 0.

Reset
REQ-024 On reset the block SHALL, immediately and in any state including mid-transaction:
  - go to IDLE
  - drive every output to 0
  - clear the latched request, with no done pulse issued
  - set the round-robin pointer so that the CPU wins the next tie

Configuration
REQ-025 With BUS_WAIT_EN defined, a TC0 or TC1 access SHALL pass from ACCESS through WAIT, holding the select and data for WAIT_CYCLES cycles via a down-counter, then go to RESP.
REQ-026 With BUS_WAIT_EN defined, DM, INT and error accesses SHALL skip WAIT.
REQ-027 Without BUS_WAIT_EN defined, the WAIT state and counter SHALL be absent, WAIT_CYCLES SHALL be ignored, and every access SHALL take 3 cycles.

Verification
REQ-028 Lone CPU read:
  - stimulus: c_addr = 0x0000_0010, m_rdata_dm = 0xDEAD_BEEF
  - response: m_sel = 4'b0001 in ACCESS; c_done for one cycle, 3 cycles after the request; c_rdata = 0xDEAD_BEEF
REQ-029 Simultaneous requests, repeated:
  - stimulus: c_req and d_req both high, for three consecutive transactions
  - response: grants in order CPU, DMA, CPU
REQ-030 DMA write:
  - stimulus: d_addr = 0x0000_7F04, d_byteen = 4'b1111, d_wdata = 0x1234
  - response: m_sel = 4'b0010 and m_byteen = 4'b1111 in ACCESS; with BUS_WAIT_EN and WAIT_CYCLES = 2, d_done arrives 5 cycles after the request
REQ-031 CPU write to unmapped address:
  - stimulus: c_addr = 0x0000_4000
  - response: m_sel = 0, m_byteen = 0; c_done and c_err pulse together; c_rdata = 0
REQ-032 Reset mid-transaction:
  - stimulus: reset asserted during ACCESS
  - response: outputs 0 immediately; no done pulse; FSM in IDLE; on the next simultaneous requests the CPU is granted
